dm_load_unit: RTL and testbench
===============================

// Module: dm_load_unit
// PURPOSE
//  Read side of the data memory: services lw/lb/lbu/lh/lhu in the M stage over a
//  req/rvalid handshake to a variable-latency memory port. Byte/half extraction
//  and sign/zero extension complement the store byte-enable path. Stalls the
//  pipeline while a load is outstanding and delivers the result to the M/W register.
// PARAMETERS
//  MAX_WAIT  16  WAIT-state cycles without rvalid before timeout (>=1, <=255)
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  reset       in   1   synchronous, active-high
//  IR_M        in   32  instruction in M stage
//  addr        in   32  byte address from ALU (M stage)
//  flush       in   1   kill M-stage instr; no new load accepted this cycle
//  mem_req     out  1   registered; high throughout WAIT
//  mem_addr    out  32  registered word address {addr[31:2],2'b00}, stable in WAIT
//  mem_rdata   in   32  read word, sampled only when mem_rvalid=1 in WAIT
//  mem_rvalid  in   1   read data valid, single-cycle pulse
//  stall       out  1   combinational; freeze F/D/E/M while high
//  ld_data     out  32  registered extended load result, valid when ld_valid=1
//  ld_valid    out  1   registered, one-cycle pulse in DONE
//  addr_err    out  1   registered one-cycle pulse: misaligned load rejected
//  timeout_err out  1   registered one-cycle pulse in DONE after timeout
// BEHAVIOUR
//  Opcodes: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101 (IR_M[31:26]).
//  is_load = load opcode & ~flush. misalign = (lw & addr[1:0]!=0) | (lh/lhu & addr[0]).
//  Reset: state=IDLE; mem_req, ld_valid, addr_err, timeout_err=0; ld_data=0;
//   mem_addr=0; wait counter=0. Reset beats every other event, incl. mid-WAIT.
//  FSM IDLE -> WAIT -> DONE -> IDLE:
//   IDLE: is_load & ~misalign -> latch mem_addr, op, A=addr[1:0]; WAIT, mem_req=1.
//         is_load & misalign -> addr_err=1 next cycle, stay IDLE, no request.
//         mem_rvalid in IDLE ignored (late response after reset or timeout).
//   WAIT: cnt++ each cycle. rvalid -> ld_data=extend(mem_rdata); DONE.
//         no rvalid and cnt==MAX_WAIT-1 -> ld_data=0, timeout_err=1; DONE.
//         rvalid on the timeout cycle wins (normal completion).
//   DONE: ld_valid=1, mem_req=0, cnt=0; unconditionally -> IDLE.
//  stall = (IDLE & is_load & ~misalign) | WAIT. stall=0 in DONE, so pipeline
//   advances on DONE's edge; the held load is never reissued.
//  flush in WAIT ignored (load completes; W stage discards). Latency: N WAIT cycles
//   (rvalid in N-th) -> stall high N+1 cycles, ld_valid in cycle N+1 after detect.
//  Extend: lw word; lb/lbu byte A (0:[7:0],1:[15:8],2:[23:16],3:[31:24]);
//   lh/lhu half A[1] (0:[15:0],1:[31:16]); lb/lh sign-, lbu/lhu zero-extend.
//  mem_addr/op/A frozen from IDLE->WAIT edge until next accepted load.
// STRUCTURE
//  Shared pkg/header: opcode defines (lw/lb/lbu/lh/lhu + sw/sb/sh), FSM state
//   encodings, IR field ranges.
//  Sub-module load_ext (combinational: op, A, word -> ld_data); also usable by a
//   single-cycle memory path.
// TESTING
//  lw addr=0x10, rdata=0x12345678 rvalid 3rd WAIT cycle -> mem_addr=0x10,
//   stall 4 cycles, ld_valid=1 cycle 5, ld_data=0x12345678.
//  lb A=3 rdata=0x80FF0102 -> 0xFFFFFF80; lbu same -> 0x00000080;
//   lh A=2 rdata=0x8001_1234 -> 0xFFFF8001; lhu A=0 -> 0x00001234.
//  lw addr=0x12 -> addr_err pulse, mem_req never high, stall=0; lh addr=0x13 same.
//  MAX_WAIT=4, no rvalid -> mem_req 4 cycles, then ld_valid=1, timeout_err=1,
//   ld_data=0; later rvalid in IDLE produces no ld_valid.
//  reset in 2nd WAIT cycle -> next cycle IDLE, mem_req=0, stall=0; subsequent
//   rvalid ignored; flush with lw in IR_M -> no request, stall=0.

Source files
------------

// File: rtl/dm_load_unit_pkg.sv
// Shared load/store decode definitions, FSM state encodings and instruction field ranges.
// Used by the load unit and by any single-cycle memory path that reuses the extender.
package dm_load_unit_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_LB  = 6'b100000;
    localparam logic [5:0] OPC_LBU = 6'b100100;
    localparam logic [5:0] OPC_LH  = 6'b100001;
    localparam logic [5:0] OPC_LHU = 6'b100101;
    localparam logic [5:0] OPC_SW  = 6'b101011;
    localparam logic [5:0] OPC_SB  = 6'b101000;
    localparam logic [5:0] OPC_SH  = 6'b101001;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} ld_state_t;
    typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_op_t;

    typedef struct packed {
        logic   is_ld;
        ld_op_t op;
    } ld_dec_t;

    function automatic ld_dec_t decode_load(input logic [5:0] opc);
        ld_dec_t d;
        d.is_ld = 1'b1;
        d.op    = LD_W;
        case (opc)
            OPC_LW:  d.op = LD_W;
            OPC_LB:  d.op = LD_B;
            OPC_LBU: d.op = LD_BU;
            OPC_LH:  d.op = LD_H;
            OPC_LHU: d.op = LD_HU;
            default: d.is_ld = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_store(input logic [5:0] opc);
        return (opc == OPC_SW) || (opc == OPC_SB) || (opc == OPC_SH);
    endfunction

endpackage

// File: rtl/dm_load_unit_if.sv
// Read port between the load unit (master) and a variable-latency data memory (slave).
// Request is held high until a single-cycle rvalid pulse answers it; no other backpressure.
interface dm_load_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_rvalid);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_rvalid);
endinterface

// File: rtl/dm_load_unit_load_ext.sv
// Combinational byte/half extraction and sign/zero extension of a loaded word.
// Zero latency, no handshake; lane chosen by the low address bits captured with the request.
module load_ext
    import dm_load_unit_pkg::*;
(
    input  ld_op_t      op_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (a_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = a_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (op_i)
            LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data_o = {24'd0, byte_sel};
            LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// M-stage load unit: IDLE->WAIT->DONE request/rvalid sequencer with timeout and misalign rejection.
// Stall is held from detect through WAIT; result pulses ld_valid one cycle after rvalid.
module dm_load_unit
    import dm_load_unit_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    IR_M,
    input  logic [31:0]    addr,
    input  logic           flush,
    dm_load_unit_if.master mem,
    output logic           stall,
    output logic [31:0]    ld_data,
    output logic           ld_valid,
    output logic           addr_err,
    output logic           timeout_err
);

    ld_state_t   state_q;
    ld_op_t      op_q;
    logic [1:0]  a_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [31:0] ld_data_q;
    logic        ld_valid_q;
    logic        addr_err_q;
    logic        timeout_err_q;

    ld_dec_t     dec;
    logic        is_load;
    logic        misalign;
    logic [31:0] ext_d;
    logic        ir_unused;

    assign dec       = decode_load(IR_M[OPC_MSB:OPC_LSB]);
    assign ir_unused = ^IR_M[OPC_LSB-1:0];
    assign is_load   = dec.is_ld & ~flush;
    assign misalign  = ((dec.op == LD_W) && (addr[1:0] != 2'b00)) ||
                       (((dec.op == LD_H) || (dec.op == LD_HU)) && addr[0]);

    load_ext u_ext (
        .op_i   (op_q),
        .a_i    (a_q),
        .word_i (mem.mem_rdata),
        .data_o (ext_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= LD_W;
            a_q           <= 2'b00;
            cnt_q         <= 8'd0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'd0;
            ld_data_q     <= 32'd0;
            ld_valid_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            ld_valid_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Any rvalid seen here is a stale answer to an abandoned request.
                    if (is_load) begin
                        if (misalign) begin
                            addr_err_q <= 1'b1;
                        end else begin
                            mem_addr_q <= {addr[31:2], 2'b00};
                            op_q       <= dec.op;
                            a_q        <= addr[1:0];
                            cnt_q      <= 8'd0;
                            mem_req_q  <= 1'b1;
                            state_q    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem.mem_rvalid) begin
                        ld_data_q  <= ext_d;
                        ld_valid_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= ST_DONE;
                    end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                        ld_data_q     <= 32'd0;
                        ld_valid_q    <= 1'b1;
                        timeout_err_q <= 1'b1;
                        mem_req_q     <= 1'b0;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt_q   <= 8'd0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Low in DONE so the pipeline advances past the held load without reissuing it.
    assign stall = ((state_q == ST_IDLE) && is_load && !misalign) || (state_q == ST_WAIT);

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign ld_data      = ld_data_q;
    assign ld_valid     = ld_valid_q;
    assign addr_err     = addr_err_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed bench for dm_load_unit: stimulus pushes expected result events, a negedge monitor pops them.
module tb_dm_load_unit;

    localparam int MAXW = 4;

    localparam logic [31:0] IR_LW  = 32'h8C00_0000;
    localparam logic [31:0] IR_LB  = 32'h8000_0000;
    localparam logic [31:0] IR_LBU = 32'h9000_0000;
    localparam logic [31:0] IR_LH  = 32'h8400_0000;
    localparam logic [31:0] IR_LHU = 32'h9400_0000;

    typedef struct {
        logic        v;
        logic        ae;
        logic        te;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M;
    logic [31:0] addr;
    logic        flush;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        addr_err;
    logic        timeout_err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    dm_load_unit_if mif ();

    dm_load_unit #(.MAX_WAIT(MAXW)) dut (
        .clk         (clk),
        .reset       (reset),
        .IR_M        (IR_M),
        .addr        (addr),
        .flush       (flush),
        .mem         (mif),
        .stall       (stall),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .addr_err    (addr_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every result/error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && (ld_valid || addr_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: ld_valid=%0b addr_err=%0b with nothing expected",
                         ld_valid, addr_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_ld_valid", 32'(ld_valid), 32'(e.v));
                chk("sb_addr_err", 32'(addr_err), 32'(e.ae));
                if (e.v) begin
                    chk("sb_timeout_err", 32'(timeout_err), 32'(e.te));
                    chk("sb_ld_data", ld_data, e.d);
                end
            end
        end
    end

    task automatic do_load(input string nm, input logic [31:0] ir, input logic [31:0] a,
                           input logic [31:0] rd, input int nwait,
                           input logic [31:0] exp_d, input logic exp_te);
        int ncyc;
        int stall_cnt;
        int req_cnt;
        ncyc = (nwait == 0) ? MAXW : nwait;
        exp_q.push_back('{1'b1, 1'b0, exp_te, exp_d});
        @(posedge clk); #1;
        IR_M = ir; addr = a; flush = 1'b0;
        @(negedge clk);
        stall_cnt = int'(stall);
        req_cnt   = 0;
        for (int w = 1; w <= ncyc; w++) begin
            @(posedge clk); #1;
            mif.mem_rvalid = 1'b0;
            if (w == nwait) begin
                mif.mem_rvalid = 1'b1;
                mif.mem_rdata  = rd;
            end
            @(negedge clk);
            stall_cnt += int'(stall);
            req_cnt   += int'(mif.mem_req);
            if (w == 1) chk({nm, "_mem_addr"}, mif.mem_addr, {a[31:2], 2'b00});
        end
        @(posedge clk); #1;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 32'hA5A5_A5A5;
        @(negedge clk);
        chk({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(ncyc + 1));
        chk({nm, "_req_cycles"}, 32'(req_cnt), 32'(ncyc));
        chk({nm, "_done_valid"}, 32'(ld_valid), 32'd1);
        chk({nm, "_done_stall"}, 32'(stall), 32'd0);
        chk({nm, "_done_req"}, 32'(mif.mem_req), 32'd0);
        @(posedge clk); #1;
        IR_M = 32'd0;
        @(negedge clk);
        chk({nm, "_no_reissue"}, 32'(mif.mem_req), 32'd0);
        chk({nm, "_valid_pulse"}, 32'(ld_valid), 32'd0);
    endtask

    task automatic do_misalign(input string nm, input logic [31:0] ir, input logic [31:0] a);
        exp_q.push_back('{1'b0, 1'b1, 1'b0, 32'd0});
        @(posedge clk); #1;
        IR_M = ir; addr = a; flush = 1'b0;
        @(negedge clk);
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        IR_M = 32'd0;
        @(negedge clk);
        chk({nm, "_addr_err"}, 32'(addr_err), 32'd1);
        chk({nm, "_req"}, 32'(mif.mem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_err_pulse"}, 32'(addr_err), 32'd0);
        chk({nm, "_req_after"}, 32'(mif.mem_req), 32'd0);
    endtask

    task automatic stray_rvalid(input string nm);
        @(posedge clk); #1;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        mif.mem_rvalid = 1'b0;
        @(negedge clk);
        chk({nm, "_no_valid"}, 32'(ld_valid), 32'd0);
        chk({nm, "_no_req"}, 32'(mif.mem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; IR_M = 32'd0; addr = 32'd0; flush = 1'b0;
        mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mif.mem_req), 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_data", ld_data, 32'd0);
        chk("rst_flags", {29'd0, ld_valid, addr_err, timeout_err}, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_load("lw",    IR_LW,  32'h0000_0010, 32'h1234_5678, 3, 32'h1234_5678, 1'b0);
        do_load("lb_a3", IR_LB,  32'h0000_0023, 32'h80FF_0102, 1, 32'hFFFF_FF80, 1'b0);
        do_load("lbu",   IR_LBU, 32'h0000_0023, 32'h80FF_0102, 2, 32'h0000_0080, 1'b0);
        do_load("lb_a1", IR_LB,  32'h0000_0021, 32'h80FF_0102, 1, 32'h0000_0001, 1'b0);
        do_load("lb_a2", IR_LB,  32'h0000_0022, 32'h80FF_0102, 2, 32'hFFFF_FFFF, 1'b0);
        do_load("lh",    IR_LH,  32'h0000_0042, 32'h8001_1234, 1, 32'hFFFF_8001, 1'b0);
        do_load("lhu",   IR_LHU, 32'h0000_0040, 32'h8001_1234, 2, 32'h0000_1234, 1'b0);
        do_load("lw_last", IR_LW, 32'h0000_0030, 32'hCAFE_F00D, MAXW, 32'hCAFE_F00D, 1'b0);

        do_misalign("mis_lw", IR_LW, 32'h0000_0012);
        do_misalign("mis_lh", IR_LH, 32'h0000_0013);

        do_load("tmo", IR_LW, 32'h0000_0080, 32'h0, 0, 32'h0000_0000, 1'b1);
        stray_rvalid("tmo_late");

        // Reset asserted during the second WAIT cycle.
        @(posedge clk); #1;
        IR_M = IR_LW; addr = 32'h0000_0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; IR_M = 32'd0;
        @(negedge clk);
        chk("rstw_req_before", 32'(mif.mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_req", 32'(mif.mem_req), 32'd0);
        chk("rstw_stall", 32'(stall), 32'd0);
        stray_rvalid("rstw_late");

        // Flushed load, deliberately misaligned: neither a request nor an addr_err.
        @(posedge clk); #1;
        IR_M = IR_LW; addr = 32'h0000_0012; flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        IR_M = 32'd0; flush = 1'b0;
        @(negedge clk);
        chk("flush_req", 32'(mif.mem_req), 32'd0);
        chk("flush_addr_err", 32'(addr_err), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
